phase_countdown_timer: RTL and testbench

//  Multi-phase traffic-light countdown timer. Cycles through NUM_PHASES light phases in order.

---
 rtl/traffic_timer_pkg.sv | 22 ++
 rtl/phase_duration_regfile.sv | 49 ++++
 rtl/phase_countdown_timer.sv | 124 ++++++++++++
 tb/tb_phase_countdown_timer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_timer_pkg.sv
// rtl/traffic_timer_pkg.sv - shared types and helpers for the phase countdown timer
package traffic_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } timer_state_t;

  // Default lamp meaning of phase indices for a simple 3-colour intersection
  typedef enum logic [1:0] {
    PH_RED    = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2
  } phase_color_t;

  // Phase index width; never narrower than one bit
  function automatic int phase_w(input int num_phases);
    return (num_phases <= 2) ? 1 : $clog2(num_phases);
  endfunction

endpackage

// File: rtl/phase_duration_regfile.sv
// rtl/phase_duration_regfile.sv - per-phase duration registers, one write port, async read
module phase_duration_regfile
  import traffic_timer_pkg::*;
#(
  parameter int WIDTH       = 6,
  parameter int NUM_PHASES  = 4,
  parameter int DEFAULT_DUR = 10,
  parameter int PW          = phase_w(NUM_PHASES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [PW-1:0]    wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] dur_q [NUM_PHASES];
  logic [WIDTH-1:0] dur_d [NUM_PHASES];

  // Write only in-range indices; out-of-range writes are dropped
  always_comb begin
    dur_d = dur_q;
    if (we && (int'(wr_idx) < NUM_PHASES)) begin
      dur_d[wr_idx] = wr_data;
    end
  end

  // Register file storage, every entry resets to the default duration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PHASES; i++) begin
        dur_q[i] <= WIDTH'(DEFAULT_DUR);
      end
    end else begin
      dur_q <= dur_d;
    end
  end

  // Combinational read returns the pre-write value, so a same-cycle load sees the old duration
  always_comb begin
    rd_data = '0;
    if (int'(rd_idx) < NUM_PHASES) begin
      rd_data = dur_q[rd_idx];
    end
  end

endmodule

// File: rtl/phase_countdown_timer.sv
// rtl/phase_countdown_timer.sv - multi-phase traffic-light countdown timer
module phase_countdown_timer
  import traffic_timer_pkg::*;
#(
  parameter int WIDTH       = 6,
  parameter int NUM_PHASES  = 4,
  parameter int PRE_WARN    = 3,
  parameter int DEFAULT_DUR = 10,
  parameter int PW          = phase_w(NUM_PHASES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             skip,
  input  logic             cfg_we,
  input  logic [PW-1:0]    cfg_idx,
  input  logic [WIDTH-1:0] cfg_data,
  output logic [PW-1:0]    phase,
  output logic [WIDTH-1:0] remaining,
  output logic             warn,
  output logic             phase_done,
  output logic             running
);

  timer_state_t     state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             warn_q, warn_d;
  logic             done_q, done_d;
  logic             running_q, running_d;

  logic [PW-1:0]    next_phase;
  logic [PW-1:0]    rd_idx;
  logic [WIDTH-1:0] rd_dur;
  logic [WIDTH-1:0] load_val;
  logic             phase_end;

  phase_duration_regfile #(
    .WIDTH       (WIDTH),
    .NUM_PHASES  (NUM_PHASES),
    .DEFAULT_DUR (DEFAULT_DUR),
    .PW          (PW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (cfg_we),
    .wr_idx  (cfg_idx),
    .wr_data (cfg_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_dur)
  );

  // Next phase index and the duration to load: phase 0 on start, else the following phase
  always_comb begin
    next_phase = (phase_q == PW'(NUM_PHASES - 1)) ? '0 : phase_q + PW'(1);
    rd_idx     = start ? '0 : next_phase;
    load_val   = (rd_dur == '0) ? WIDTH'(1) : rd_dur;
  end

  // FSM and down-counter next state; priority stop > start > skip > hold > tick
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    phase_end = 1'b0;
    if (stop) begin
      state_d = IDLE;
      phase_d = '0;
      rem_d   = '0;
    end else if (start) begin
      state_d = RUN;
      phase_d = '0;
      rem_d   = load_val;
    end else if (state_q != IDLE) begin
      if (skip) begin
        phase_end = 1'b1;
      end else if (state_q == HOLD) begin
        if (!hold) state_d = RUN;
      end else if (hold) begin
        state_d = HOLD;
      end else if (tick) begin
        if (rem_q > WIDTH'(1)) rem_d = rem_q - WIDTH'(1);
        else                   phase_end = 1'b1;
      end
      if (phase_end) begin
        done_d  = 1'b1;
        phase_d = next_phase;
        rem_d   = load_val;
      end
    end
    running_d = (state_d != IDLE);
    warn_d    = running_d && (rem_d <= WIDTH'(PRE_WARN));
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      rem_q     <= '0;
      warn_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      rem_q     <= rem_d;
      warn_q    <= warn_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign phase      = phase_q;
  assign remaining  = rem_q;
  assign warn       = warn_q;
  assign phase_done = done_q;
  assign running    = running_q;

endmodule

// File: tb/tb_phase_countdown_timer.sv
// tb/tb_phase_countdown_timer.sv - self-checking bench with behavioural reference model
module tb_phase_countdown_timer;

  localparam int NP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, start = 1'b0, stop = 1'b0, hold = 1'b0, skip = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [5:0] cfg_data = '0;
  logic [1:0] phase;
  logic [5:0] remaining;
  logic       warn, phase_done, running;

  int checks = 0;
  int errors = 0;

  phase_countdown_timer dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop), .hold(hold),
    .skip(skip), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .phase(phase), .remaining(remaining), .warn(warn), .phase_done(phase_done),
    .running(running)
  );

  always #5 clk = ~clk;

  // Reference model: an active flag, a held flag, a phase number and a tick budget
  int m_dur [NP];
  bit m_act, m_held, m_done;
  int m_ph, m_rem;

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int  nx;
    bit  ends;
    if (!rst_n) begin
      for (int i = 0; i < NP; i++) m_dur[i] = 10;
      m_act = 0; m_held = 0; m_done = 0; m_ph = 0; m_rem = 0;
    end else begin
      m_done = 0;
      ends   = 0;
      nx     = (m_ph + 1) % NP;
      if (stop) begin
        m_act = 0; m_held = 0; m_ph = 0; m_rem = 0;
      end else if (start) begin
        m_act = 1; m_held = 0; m_ph = 0; m_rem = eff(m_dur[0]);
      end else if (m_act) begin
        if (skip) ends = 1;
        else if (m_held) m_held = hold;
        else if (hold) m_held = 1;
        else if (tick) begin
          if (m_rem > 1) m_rem = m_rem - 1;
          else ends = 1;
        end
        if (ends) begin
          m_done = 1; m_ph = nx; m_rem = eff(m_dur[nx]);
        end
      end
      if (cfg_we && int'(cfg_idx) < NP) m_dur[cfg_idx] = int'(cfg_data);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of every output against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_phase", int'(phase), m_ph);
      chk("m_remaining", int'(remaining), m_rem);
      chk("m_warn", int'(warn), int'(m_act && m_rem <= 3));
      chk("m_phase_done", int'(phase_done), int'(m_done));
      chk("m_running", int'(running), int'(m_act));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int pulses, warns;

  initial begin
    // 1: reset values, then four default phases with tick every cycle
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("rst_phase", int'(phase), 0);
    chk("rst_remaining", int'(remaining), 0);
    chk("rst_warn", int'(warn), 0);
    chk("rst_done", int'(phase_done), 0);
    chk("rst_running", int'(running), 0);
    start = 1; cyc(1); start = 0;
    chk("t1_load", int'(remaining), 10);
    chk("t1_running", int'(running), 1);
    tick = 1;
    pulses = 0; warns = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      pulses += int'(phase_done);
      warns  += int'(warn);
    end
    chk("t1_pulses", pulses, 4);
    chk("t1_warns", warns, 12);
    chk("t1_phase", int'(phase), 0);
    chk("t1_rem", int'(remaining), 10);

    // 2: reprogram phase 1 mid-count; current count unaffected, next visit uses new value
    cyc(13);
    chk("t2_phase1", int'(phase), 1);
    chk("t2_rem7", int'(remaining), 7);
    cfg_we = 1; cfg_idx = 2'd1; cfg_data = 6'd2; cyc(1); cfg_we = 0;
    chk("t2_rem6", int'(remaining), 6);
    cyc(6);
    chk("t2_phase2", int'(phase), 2);
    chk("t2_rem10", int'(remaining), 10);
    cyc(30);
    chk("t2_phase1_again", int'(phase), 1);
    chk("t2_short", int'(remaining), 2);
    cyc(2);
    chk("t2_after_short", int'(phase), 2);

    // 3: hold freezes the count with tick active
    cyc(4);
    chk("t3_rem6", int'(remaining), 6);
    hold = 1; cyc(5);
    chk("t3_held", int'(remaining), 6);
    chk("t3_running", int'(running), 1);
    hold = 0; cyc(1);
    chk("t3_resume", int'(remaining), 6);
    cyc(1);
    chk("t3_dec", int'(remaining), 5);

    // 4: skip together with tick at remaining 4 in phase 2
    cyc(1);
    chk("t4_rem4", int'(remaining), 4);
    skip = 1; cyc(1); skip = 0; tick = 0;
    chk("t4_phase", int'(phase), 3);
    chk("t4_rem", int'(remaining), 10);
    chk("t4_done", int'(phase_done), 1);
    cyc(1);
    chk("t4_done_clear", int'(phase_done), 0);

    // 5: zero duration loads as one
    stop = 1; cyc(1); stop = 0;
    chk("t5_idle_running", int'(running), 0);
    cfg_we = 1; cfg_idx = 2'd0; cfg_data = 6'd0; cyc(1); cfg_we = 0;
    start = 1; cyc(1); start = 0;
    chk("t5_rem1", int'(remaining), 1);
    chk("t5_warn", int'(warn), 1);
    tick = 1; cyc(1);
    chk("t5_phase1", int'(phase), 1);
    chk("t5_rem2", int'(remaining), 2);

    // 6: asynchronous reset mid-phase restores outputs and durations
    cyc(2);
    cyc(5);
    chk("t6_phase2", int'(phase), 2);
    chk("t6_rem5", int'(remaining), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_phase", int'(phase), 0);
    chk("t6_rst_rem", int'(remaining), 0);
    chk("t6_rst_running", int'(running), 0);
    tick = 0;
    cyc(1);
    rst_n = 1'b1;
    start = 1; cyc(1); start = 0;
    chk("t6_restart_phase", int'(phase), 0);
    chk("t6_restart_rem", int'(remaining), 10);

    // Randomized traffic, checked every cycle against the model
    for (int i = 0; i < 4000; i++) begin
      tick   = ($urandom_range(0, 1) == 1);
      start  = ($urandom_range(0, 99) < 2);
      stop   = ($urandom_range(0, 99) < 2);
      skip   = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 8) hold = ~hold;
      cfg_we   = ($urandom_range(0, 99) < 10);
      cfg_idx  = 2'($urandom_range(0, 3));
      cfg_data = 6'($urandom_range(0, 12));
      if ($urandom_range(0, 999) < 3) begin
        #2 rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
      end
      cyc(1);
    end
    tick = 0; start = 0; stop = 0; skip = 0; hold = 0; cfg_we = 0;
    cyc(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
